// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around mem_port_arbiter.
// Each requester raises req and holds its fields stable until gnt is high. The request is accepted in that cycle, and rvalid follows exactly one cycle later.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 34,
  parameter int MEM_AW     = 16
);
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;

  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [31:0]           data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;

  logic                  mem_en_o;
  logic [MEM_AW-1:0]     mem_addr_o;
  logic [3:0]            mem_we_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  // Debug view of the arbitration state (wait counter or round-robin pointer)
  logic [3:0]            dbg_wait_cnt_o;
  logic                  dbg_rr_last_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_en_o, mem_addr_o, mem_we_o, mem_wdata_o,
    output dbg_wait_cnt_o, dbg_rr_last_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_en_o, mem_addr_o, mem_we_o, mem_wdata_o,
    input  dbg_wait_cnt_o, dbg_rr_last_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data ports.
// Data wins by default with a MAX_WAIT fetch starvation guard; define MEM_PORT_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 34,
   parameter int MEM_AW     = 16,
   parameter int MAX_WAIT   = 4
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
   end
   if ($bits(bus.instr_addr_i) != ADDR_WIDTH) begin : g_bad_addr_width
      $error("mem_port_arbiter: interface ADDR_WIDTH mismatch");
   end

   logic resp_pend_q, resp_pend_d;
   logic resp_owner_q, resp_owner_d;
   logic instr_win, instr_gnt, data_gnt;
`ifdef MEM_PORT_ARB_RR_EN
   logic rr_last_q, rr_last_d;
`else
   localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);
   logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

   // Upper and byte-offset address bits are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.instr_addr_i, bus.data_addr_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_pend_q  <= 1'b0;
         resp_owner_q <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
         rr_last_q    <= 1'b0;
`else
         wait_cnt_q   <= 4'd0;
`endif
      end else begin
         resp_pend_q  <= resp_pend_d;
         resp_owner_q <= resp_owner_d;
`ifdef MEM_PORT_ARB_RR_EN
         rr_last_q    <= rr_last_d;
`else
         wait_cnt_q   <= wait_cnt_d;
`endif
      end
   end

   always_comb begin
      resp_pend_d  = instr_gnt | data_gnt;
      resp_owner_d = resp_owner_q;
      if (data_gnt)       resp_owner_d = 1'b1;
      else if (instr_gnt) resp_owner_d = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      rr_last_d = rr_last_q;
      if (data_gnt)       rr_last_d = 1'b1;
      else if (instr_gnt) rr_last_d = 1'b0;
`else
      wait_cnt_d = 4'd0;
      if (bus.instr_req_i && !instr_gnt) wait_cnt_d = wait_cnt_q + 4'd1;
`endif
   end

   always_comb begin
`ifdef MEM_PORT_ARB_RR_EN
      instr_win = bus.instr_req_i & (~bus.data_req_i | rr_last_q);
      bus.dbg_wait_cnt_o = 4'd0;
      bus.dbg_rr_last_o  = rr_last_q;
`else
      // Fetch is forced through once it has lost MAX_WAIT cycles in a row.
      instr_win = bus.instr_req_i & (~bus.data_req_i | (wait_cnt_q == MaxWaitC));
      bus.dbg_wait_cnt_o = wait_cnt_q;
      bus.dbg_rr_last_o  = 1'b0;
`endif
      instr_gnt = instr_win & ~rst;
      data_gnt  = bus.data_req_i & ~instr_win & ~rst;

      bus.instr_gnt_o = instr_gnt;
      bus.data_gnt_o  = data_gnt;
      bus.mem_en_o    = instr_gnt | data_gnt;
      bus.mem_addr_o  = '0;
      bus.mem_we_o    = 4'd0;
      bus.mem_wdata_o = 32'd0;
      if (instr_gnt) begin
         bus.mem_addr_o = bus.instr_addr_i[MEM_AW+1:2];
      end else if (data_gnt) begin
         bus.mem_addr_o  = bus.data_addr_i[MEM_AW+1:2];
         bus.mem_we_o    = bus.data_be_i & {4{bus.data_we_i}};
         bus.mem_wdata_o = bus.data_wdata_i;
      end

      bus.instr_rvalid_o = resp_pend_q & ~resp_owner_q;
      bus.data_rvalid_o  = resp_pend_q & resp_owner_q;
      bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : 32'd0;
      bus.data_rdata_o   = bus.data_rvalid_o  ? bus.mem_rdata_i : 32'd0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a reference arbitration model and RAM model.
// Builds with or without MEM_PORT_ARB_RR_EN.
module tb_mem_port_arbiter;
  localparam int AW       = 34;
  localparam int MAW      = 16;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .MEM_AW(MAW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_AW(MAW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] exp_q[$];          // {owner, check_data, data}
  logic [31:0] ram [0:65535];
  logic [31:0] ref_mem [0:15];
  int          losses;
  bit          last_owner;
  string       gnt_trace;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory macro: read-first, 1-cycle read latency, byte write strobes
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      bus.mem_rdata_i <= ram[bus.mem_addr_o];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b]) ram[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
    end
  end

  function automatic logic [AW-1:0] make_addr(input int widx);
    logic [AW-1:0] a;
    a = AW'({$urandom(), $urandom()});
    a[MAW+1:2] = MAW'(widx);
    return a;
  endfunction

  task automatic issue(input bit r, input bit i_req, input logic [AW-1:0] i_addr,
                       input bit d_req, input logic [AW-1:0] d_addr, input bit d_we,
                       input logic [3:0] d_be, input logic [31:0] d_wdata,
                       output bit got_i, output bit got_d);
    bit          win_i, win_d;
    logic [15:0] ea;
    logic [3:0]  ewe;
    logic [31:0] ewd, nv;
    int          idx;
    @(posedge clk);
    #1;
    rst              = r;
    bus.instr_req_i  = i_req;
    bus.instr_addr_i = i_addr;
    bus.data_req_i   = d_req;
    bus.data_addr_i  = d_addr;
    bus.data_we_i    = d_we;
    bus.data_be_i    = d_be;
    bus.data_wdata_i = d_wdata;
    @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
    win_i = i_req && (!d_req || last_owner);
    check("rr_last", bus.dbg_rr_last_o, last_owner);
`else
    win_i = i_req && (!d_req || losses == MAX_WAIT);
    check("wait_cnt", bus.dbg_wait_cnt_o, losses);
`endif
    if (r) win_i = 1'b0;
    win_d = !r && d_req && !win_i;
    ea = 16'd0; ewe = 4'd0; ewd = 32'd0;
    if (win_i) ea = i_addr[MAW+1:2];
    else if (win_d) begin
      ea  = d_addr[MAW+1:2];
      ewe = d_we ? d_be : 4'd0;
      ewd = d_wdata;
    end
    check("instr_gnt", bus.instr_gnt_o, win_i);
    check("data_gnt", bus.data_gnt_o, win_d);
    check("mem_en", bus.mem_en_o, win_i | win_d);
    check("mem_addr", bus.mem_addr_o, ea);
    check("mem_we", bus.mem_we_o, ewe);
    check("mem_wdata", bus.mem_wdata_o, ewd);
    idx = int'(ea[3:0]);
    if (win_i) exp_q.push_back({1'b0, 1'b1, ref_mem[idx]});
    if (win_d) begin
      if (d_we) begin
        exp_q.push_back({1'b1, 1'b0, 32'd0});
        nv = ref_mem[idx];
        for (int b = 0; b < 4; b++) if (d_be[b]) nv[b*8 +: 8] = d_wdata[b*8 +: 8];
        ref_mem[idx] = nv;
      end else begin
        exp_q.push_back({1'b1, 1'b1, ref_mem[idx]});
      end
    end
    if (r) begin
      losses = 0;
      last_owner = 1'b0;
    end else begin
      if (i_req && !win_i) losses++;
      else losses = 0;
      if (win_i) last_owner = 1'b0;
      else if (win_d) last_owner = 1'b1;
    end
    gnt_trace = {gnt_trace, win_i ? "I" : (win_d ? "D" : "-")};
    got_i = win_i;
    got_d = win_d;
  endtask

  // Response monitor: every accepted request must answer one cycle later.
  initial begin
    logic [33:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instr_rvalid", bus.instr_rvalid_o, !e[33]);
        check("data_rvalid", bus.data_rvalid_o, e[33]);
        if (!e[33]) begin
          check("instr_rdata", bus.instr_rdata_o, e[31:0]);
          check("data_rdata_idle", bus.data_rdata_o, 32'd0);
        end else begin
          check("instr_rdata_idle", bus.instr_rdata_o, 32'd0);
          if (e[32]) check("load_rdata", bus.data_rdata_o, e[31:0]);
          else       check("store_rdata", bus.data_rdata_o, bus.mem_rdata_i);
        end
      end else begin
        check("instr_rvalid_idle", bus.instr_rvalid_o, 1'b0);
        check("data_rvalid_idle", bus.data_rvalid_o, 1'b0);
      end
    end
  end

  initial begin
    bit              gi, gd;
    bit              pi, pd;
    logic [AW-1:0]   ia, da;
    bit              dwe;
    logic [3:0]      dbe;
    logic [31:0]     dwd;
    string           exp_trace;

    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom();
    ref_mem[4] = 32'hDEADBEEF;
    for (int i = 0; i < 65536; i++) ram[i] = (i < 16) ? ref_mem[i] : 32'd0;
    rst = 1'b1;
    bus.instr_req_i = 1'b0; bus.instr_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_addr_i = '0; bus.data_we_i = 1'b0;
    bus.data_be_i = 4'd0; bus.data_wdata_i = 32'd0; bus.mem_rdata_i = 32'd0;
    losses = 0; last_owner = 1'b0; gnt_trace = "";

    repeat (3) issue(1, 0, '0, 0, '0, 0, 4'd0, 32'd0, gi, gd);
    repeat (3) issue(0, 0, '0, 0, '0, 0, 4'd0, 32'd0, gi, gd);

    // Sustained contention right after reset
    gnt_trace = "";
`ifdef MEM_PORT_ARB_RR_EN
    exp_trace = "DIDIDI";
    repeat (6) issue(0, 1, make_addr(4), 1, make_addr(1), 0, 4'hF, 32'd0, gi, gd);
`else
    exp_trace = "DDDDIDDDDI";
    repeat (10) issue(0, 1, make_addr(4), 1, make_addr(1), 0, 4'hF, 32'd0, gi, gd);
`endif
    n_checks++;
    if (gnt_trace != exp_trace) begin
      n_fail++;
      $display("FAIL contention_order: got %s expected %s", gnt_trace, exp_trace);
    end

    issue(0, 1, 34'h10, 0, '0, 0, 4'd0, 32'd0, gi, gd);
    issue(0, 0, '0, 1, 34'h20, 1, 4'b0011, 32'h1234_5678, gi, gd);
    issue(0, 0, '0, 1, 34'h20, 0, 4'b0000, 32'd0, gi, gd);
    issue(0, 0, '0, 0, '0, 0, 4'd0, 32'd0, gi, gd);

    // Reset asserted while both ports keep requesting
    issue(0, 1, make_addr(2), 0, '0, 0, 4'd0, 32'd0, gi, gd);
    repeat (2) issue(1, 1, make_addr(3), 1, make_addr(5), 1, 4'hF, 32'hA5A5_5A5A, gi, gd);
    issue(0, 1, make_addr(3), 1, make_addr(5), 1, 4'hF, 32'hA5A5_5A5A, gi, gd);

    pi = 1'b0; pd = 1'b0; ia = '0; da = '0; dwe = 1'b0; dbe = 4'd0; dwd = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!pi && $urandom_range(0, 9) < 7) begin
        pi = 1'b1;
        ia = make_addr($urandom_range(0, 15));
      end
      if (!pd && $urandom_range(0, 9) < 7) begin
        pd  = 1'b1;
        da  = make_addr($urandom_range(0, 15));
        dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom_range(0, 15));
        dwd = $urandom();
      end
      issue(0, pi, ia, pd, da, dwe, dbe, dwd, gi, gd);
      if (gi) pi = 1'b0;
      if (gd) pd = 1'b0;
    end
    repeat (2) issue(0, 0, '0, 0, '0, 0, 4'd0, 32'd0, gi, gd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and data port.
- Sits between the core's instr/data request interfaces and a single-port memory macro with 1-cycle read latency.
- Grants one requester per cycle and routes the returned read data and rvalid back to the owner.
- Guarantees instruction fetch cannot starve under continuous data traffic.

Parameters:
- ADDR_WIDTH, 34: width of the requester address buses.
- MEM_AW, 16: memory word-address width; mem_addr_o = granted addr[MEM_AW+1:2].
- MAX_WAIT, 4: consecutive cycles instr may lose arbitration before it is forced to win (1..15).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- instr_req_i  input  1  fetch request
- instr_addr_i  input  ADDR_WIDTH  fetch byte address
- instr_gnt_o  output  1  fetch accepted this cycle
- instr_rvalid_o  output  1  fetch data valid
- instr_rdata_o  output  32  fetch data
- data_req_i  input  1  load/store request
- data_addr_i  input  ADDR_WIDTH  data byte address
- data_we_i  input  1  1 = store
- data_be_i  input  4  byte enables
- data_wdata_i  input  32  store data
- data_gnt_o  output  1  data accepted this cycle
- data_rvalid_o  output  1  data response valid (loads and stores)
- data_rdata_o  output  32  load data
- mem_en_o  output  1  memory enable
- mem_addr_o  output  MEM_AW  memory word address
- mem_we_o  output  4  per-byte write strobe = be & {4{we}} of granted data request, 0 for fetch
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, valid one cycle after mem_en_o

Behaviour:
- Grant is combinational, in the same cycle as the request.
  - At most one of instr_gnt_o/data_gnt_o is high per cycle.
  - mem_en_o = instr_gnt_o | data_gnt_o.
  - The mem_* outputs carry the granted requester's fields; when idle they are 0.
- Only one requester active: that requester is granted.
- Both active: the policy below decides; the loser holds its request and fields stable.
- Default policy (macro off):
  - Data wins.
  - wait_cnt (4 bits) increments each cycle instr_req_i=1 and instr loses.
  - When wait_cnt == MAX_WAIT, instr wins that cycle regardless of data.
  - wait_cnt clears on any instr grant or when instr_req_i=0.
- Response path:
  - Registers resp_owner (0 = instr, 1 = data) and resp_pend on every grant.
  - Next cycle: the owner's rvalid=1 for exactly one cycle; its rdata = mem_rdata_i.
  - The non-owner's rvalid=0 and its rdata=0.
  - A store also produces data_rvalid_o one cycle after grant; data_rdata_o is don't-care and is driven with mem_rdata_i.
- Throughput: one grant per cycle; back-to-back grants to alternating owners are legal, with each response one cycle after its grant.
- Latency: grant to rvalid = exactly 1 cycle.
- Reset (rst=1 on a clock edge):
  - resp_pend=0, resp_owner=0, wait_cnt=0, rr_last=0.
  - Both rvalid outputs are 0 from the following cycle.
- Reset mid-operation: any response pending at the reset edge is dropped, with no rvalid.
- While rst=1, gnt outputs and mem_en_o are forced 0 combinationally.
- Address bits above MEM_AW+1 are ignored; no decode or error response.
- MAX_WAIT=0 is illegal; an elaboration-time assertion flags it.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined:
  - Round-robin replaces data priority and wait_cnt.
  - rr_last (1 bit) records the last granted owner and updates only on grants.
  - On contention, the requester not equal to rr_last wins.
  - A single requester is always granted.
- Undefined: data priority with the MAX_WAIT starvation guard described above; no rr_last register.

Test Plan:
- Single fetch: instr_req=1 at cycle 0 with addr 0x0000_0010, mem_rdata=0xDEADBEEF at cycle 1 -> instr_gnt=1 @0, mem_addr=0x0004, instr_rvalid=1 with rdata 0xDEADBEEF @1, data_rvalid=0.
- Store then load: data store addr 0x20, be=4'b0011, wdata 0x1234_5678, then load of the same address -> mem_we=4'b0011 @0, mem_we=0 @1, data_rvalid=1 @1 and @2.
- Contention with default build and MAX_WAIT=4: both request continuously for 10 cycles -> grants D D D D I D D D D I; wait_cnt returns to 0 after each I grant.
- Contention with MEM_PORT_ARB_RR_EN defined: both request for 6 cycles, rr_last=0 at start -> grants D I D I D I; every rvalid goes to the correct owner one cycle later.
- Reset mid-operation: instr granted at cycle 5, rst=1 at the cycle-5 edge -> no instr_rvalid at cycle 6; gnt=0 while rst=1; normal grant on the first cycle after rst falls.
- Idle: no requests for 3 cycles -> mem_en=0, mem_we=0, mem_addr=0, both rvalid=0.
